// File: rtl/brick_hit_checker_pkg.sv
// Shared types and limits for the brick collision checker.
package brick_hit_checker_pkg;

  localparam int unsigned COORD_W  = 10;
  localparam int unsigned HEALTH_W = 2;

  typedef logic [COORD_W-1:0]  coord_t;
  typedef logic [HEALTH_W-1:0] health_t;

  localparam coord_t SCREEN_MAX_X = 10'd639;
  localparam coord_t SCREEN_MAX_Y = 10'd479;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_EVAL  = 3'd3,
    S_WRITE = 3'd4,
    S_NEXT  = 3'd5,
    S_DONE  = 3'd6
  } state_e;

endpackage

// File: rtl/brick_hit_checker_corner_gen.sv
// Holds the ball origin for one check and derives corner k plus an off-screen flag.
module brick_hit_checker_corner_gen
  import brick_hit_checker_pkg::*;
#(
  parameter coord_t BALL_SIZE = 10'd4,
  parameter coord_t MAX_X     = SCREEN_MAX_X,
  parameter coord_t MAX_Y     = SCREEN_MAX_Y
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         load,
  input  logic [9:0]   base_x_in,
  input  logic [9:0]   base_y_in,
  input  logic [1:0]   k,
  output logic [9:0]   corner_x,
  output logic [9:0]   corner_y,
  output logic         out_of_range
);

  localparam coord_t EDGE = BALL_SIZE - 10'd1;

  coord_t base_x_q, base_x_d;
  coord_t base_y_q, base_y_d;
  logic [COORD_W:0] sum_x, sum_y;

  always_comb begin
    base_x_d = load ? base_x_in : base_x_q;
    base_y_d = load ? base_y_in : base_y_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      base_x_q <= '0;
      base_y_q <= '0;
    end else begin
      base_x_q <= base_x_d;
      base_y_q <= base_y_d;
    end
  end

  // Bit 0 of k selects the right edge, bit 1 the bottom edge.
  always_comb begin
    sum_x        = {1'b0, base_x_q} + {1'b0, (k[0] ? EDGE : '0)};
    sum_y        = {1'b0, base_y_q} + {1'b0, (k[1] ? EDGE : '0)};
    corner_x     = sum_x[COORD_W-1:0];
    corner_y     = sum_y[COORD_W-1:0];
    out_of_range = sum_x[COORD_W] | sum_y[COORD_W] |
                   (corner_x > MAX_X) | (corner_y > MAX_Y);
  end

endmodule

// File: rtl/brick_hit_checker.sv
// Probes the four ball corners against brick memory and decrements each live brick once.
module brick_hit_checker
  import brick_hit_checker_pkg::*;
#(
  parameter coord_t      BALL_SIZE    = 10'd4,
  parameter int unsigned READ_LATENCY = 1,
  parameter coord_t      MAX_X        = SCREEN_MAX_X,
  parameter coord_t      MAX_Y        = SCREEN_MAX_Y
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  input  logic [9:0]   ball_x,
  input  logic [9:0]   ball_y,
  input  logic [1:0]   mem_health,
  input  logic [9:0]   mem_x,
  input  logic [9:0]   mem_y,
  output logic [9:0]   mem_x_in,
  output logic [9:0]   mem_y_in,
  output logic         mem_wren,
  output logic [1:0]   mem_health_in,
  output logic         busy,
  output logic         done,
  output logic [3:0]   hit_mask,
  output logic [2:0]   destroyed
);

  localparam logic [1:0] LAT_LOAD = 2'(READ_LATENCY);

  state_e     state_q, state_d;
  logic [1:0] k_q, k_d;
  logic [1:0] lat_q, lat_d;
  coord_t     x_in_q, x_in_d;
  coord_t     y_in_q, y_in_d;
  health_t    health_q, health_d;
  logic [3:0] hit_mask_q, hit_mask_d;
  logic [2:0] destroyed_q, destroyed_d;
  logic [3:0] hit_vld_q, hit_vld_d;
  coord_t     hit_x_q [4];
  coord_t     hit_x_d [4];
  coord_t     hit_y_q [4];
  coord_t     hit_y_d [4];

  logic       load;
  coord_t     corner_x, corner_y;
  logic       corner_oor;
  logic       list_match;

  brick_hit_checker_corner_gen #(
    .BALL_SIZE (BALL_SIZE),
    .MAX_X     (MAX_X),
    .MAX_Y     (MAX_Y)
  ) u_corner_gen (
    .clk          (clk),
    .resetn       (resetn),
    .load         (load),
    .base_x_in    (ball_x),
    .base_y_in    (ball_y),
    .k            (k_q),
    .corner_x     (corner_x),
    .corner_y     (corner_y),
    .out_of_range (corner_oor)
  );

  // Each corner owns slot k of the hit list, so no separate fill pointer is needed.
  always_comb begin
    list_match = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (hit_vld_q[i] && hit_x_q[i] == mem_x && hit_y_q[i] == mem_y) list_match = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    lat_d       = lat_q;
    x_in_d      = x_in_q;
    y_in_d      = y_in_q;
    health_d    = health_q;
    hit_mask_d  = hit_mask_q;
    destroyed_d = destroyed_q;
    hit_vld_d   = hit_vld_q;
    hit_x_d     = hit_x_q;
    hit_y_d     = hit_y_q;
    load        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          load        = 1'b1;
          hit_mask_d  = '0;
          destroyed_d = '0;
          hit_vld_d   = '0;
          k_d         = '0;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (corner_oor) begin
          state_d = S_NEXT;
        end else begin
          x_in_d  = corner_x;
          y_in_d  = corner_y;
          lat_d   = LAT_LOAD;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        lat_d = lat_q - 2'd1;
        if (lat_q == 2'd1) state_d = S_EVAL;
      end
      S_EVAL: begin
        if (mem_health == '0) begin
          state_d = S_NEXT;
        end else begin
          hit_mask_d[k_q] = 1'b1;
          if (list_match) begin
            state_d = S_NEXT;
          end else begin
            hit_vld_d[k_q] = 1'b1;
            hit_x_d[k_q]   = mem_x;
            hit_y_d[k_q]   = mem_y;
            health_d       = mem_health;
            state_d        = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        if (health_q == 2'd1) destroyed_d = destroyed_q + 3'd1;
        state_d = S_NEXT;
      end
      S_NEXT: begin
        if (k_q == 2'd3) begin
          state_d = S_DONE;
        end else begin
          k_d     = k_q + 2'd1;
          state_d = S_ISSUE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      lat_q       <= '0;
      x_in_q      <= '0;
      y_in_q      <= '0;
      health_q    <= '0;
      hit_mask_q  <= '0;
      destroyed_q <= '0;
      hit_vld_q   <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        hit_x_q[i] <= '0;
        hit_y_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      lat_q       <= lat_d;
      x_in_q      <= x_in_d;
      y_in_q      <= y_in_d;
      health_q    <= health_d;
      hit_mask_q  <= hit_mask_d;
      destroyed_q <= destroyed_d;
      hit_vld_q   <= hit_vld_d;
      hit_x_q     <= hit_x_d;
      hit_y_q     <= hit_y_d;
    end
  end

  // Write strobe decodes straight from the state flop so reset kills it immediately.
  always_comb begin
    mem_x_in      = x_in_q;
    mem_y_in      = y_in_q;
    mem_wren      = (state_q == S_WRITE);
    mem_health_in = mem_wren ? (health_q - 2'd1) : '0;
    busy          = (state_q != S_IDLE) && (state_q != S_DONE);
    done          = (state_q == S_DONE);
    hit_mask      = hit_mask_q;
    destroyed     = destroyed_q;
  end

endmodule

// File: doc/brick_hit_checker.md
Name: brick_hit_checker

Overview:
- Collision stage directly upstream of the brick health memory; sole driver of its x_in, y_in, wren and health_in.
- On each start request it probes the four corners of the ball bounding box against the brick grid.
- For each corner that lands in a live brick (health != 0), it decrements that brick's health once.
- Reports which corners hit so the ball-motion logic can reflect the ball.
- Handshake per check is start/done, once per game frame.

Parameters:
- BALL_SIZE, 10'd4, ball edge length in pixels; corners are (bx,by), (bx+S-1,by), (bx,by+S-1), (bx+S-1,by+S-1).
- READ_LATENCY, 1, clocks from x_in/y_in valid to health valid at the memory output (1 or 2).
- MAX_X, 10'd639, largest on-screen x; corner coordinates above this are skipped.
- MAX_Y, 10'd479, largest on-screen y; corner coordinates above this are skipped.

Ports:
- clk  in  1  system clock, single clock domain
- resetn  in  1  asynchronous active-low reset
- start  in  1  pulse; begin a check with ball_x/ball_y sampled this cycle
- ball_x  in  10  ball top-left x, pixels
- ball_y  in  10  ball top-left y, pixels
- mem_health  in  2  health returned by brick memory
- mem_x  in  10  brick-aligned x returned by brick memory
- mem_y  in  10  brick-aligned y returned by brick memory
- mem_x_in  out  10  probe x to brick memory
- mem_y_in  out  10  probe y to brick memory
- mem_wren  out  1  write strobe to brick memory
- mem_health_in  out  2  write data (decremented health)
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse, check complete
- hit_mask  out  4  bit k set if corner k hit a live brick; valid at done, held until next start
- destroyed  out  3  count of bricks reduced to 0 this check (0..4); valid at done

Behaviour:
- Reset (async, resetn=0):
  - FSM goes to IDLE.
  - All outputs 0; stored hit list cleared; corner index cleared.
- start handling:
  - start is ignored while busy.
  - start in IDLE latches ball_x/ball_y, clears hit_mask, destroyed and hit list, sets k=0, and moves to ISSUE.
- ISSUE:
  - Drive mem_x_in/mem_y_in with corner k; addition is 10-bit and wraps.
  - A corner whose sum carries out, or exceeds MAX_X/MAX_Y, is skipped: go to NEXT with no memory access.
  - Otherwise load the latency counter with READ_LATENCY and go to WAIT.
- WAIT:
  - Hold mem_x_in/mem_y_in stable; decrement the counter.
  - Go to EVAL when the counter reaches 0.
- EVAL (mem_health, mem_x, mem_y valid this cycle):
  - If mem_health == 0, go to NEXT.
  - Else if (mem_x, mem_y) equals an entry in the hit list, set hit_mask[k] without writing, then go to NEXT. This guarantees one decrement per brick per check.
  - Else set hit_mask[k], append (mem_x, mem_y) to the hit list (4 entries), and go to WRITE.
- WRITE (exactly one cycle):
  - mem_wren=1 and mem_health_in=mem_health-1, with the same x_in/y_in held.
  - If the result is 0, increment destroyed.
  - Go to NEXT.
- NEXT:
  - If k==3, go to DONE; else k=k+1 and go to ISSUE.
- DONE:
  - done=1 for one cycle, busy drops in the same cycle, return to IDLE.
- Outputs outside WRITE:
  - mem_wren=0 and mem_health_in=0.
  - mem_x_in/mem_y_in hold their last value in IDLE.
- Latency: worst case with all corners live and distinct, READ_LATENCY=1, is start + 1 + 4x(ISSUE+WAIT+EVAL+WRITE) + NEXT overhead.
  - Exact count is fixed by the FSM above; the bench checks done occurs within 24 cycles.
- Reset asserted mid-check:
  - Immediate abort; mem_wren forced 0 asynchronously, so no partial write occurs after reset.
  - No done pulse is issued.

Decomposition:
- Shared package/macros:
  - FSM state encodings IDLE, ISSUE, WAIT, EVAL, WRITE, NEXT, DONE (3-bit).
  - Health width 2; coordinate width 10.
  - Screen limits 639/479.
- Sub-module corner_gen (combinational + registered base): given base x/y, BALL_SIZE and index k, outputs corner x/y and an out_of_range flag.
- Hit-list storage and compare stay in the top level.

Test Plan:
- Single live brick under all 4 corners, health=3, ball (100,60): exactly one write of 2; hit_mask=4'b1111; destroyed=0; done once.
- Corners straddle two bricks, healths 1 and 2: writes 0 and 1; hit_mask matches the corners in each brick; destroyed=1.
- All probed healths 0: no mem_wren ever asserted; hit_mask=0; destroyed=0; done pulse within 24 cycles.
- Ball at (638,478) with BALL_SIZE=4: corners 1-3 skipped with no memory access; only corner 0 probed.
- start pulsed again while busy: ignored; second done does not occur; results reflect the first request only.
- resetn dropped during WRITE of corner 2: mem_wren=0 in the same cycle; outputs 0; next start runs a full, clean check.
